// File: rtl/sram_fifo_ctrl.sv
// FIFO controller for a 1r1w SRAM macro: push stream -> macro write port, macro read port
// -> 2-entry prefetch buffer -> zero-bubble pop stream.
module sram_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned OB_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    localparam logic [ADDR_WIDTH:0] SRAM_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   sram_cnt_q, sram_cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [DATA_WIDTH-1:0] ob_q [OB_DEPTH];
    logic [DATA_WIDTH-1:0] ob_d [OB_DEPTH];
    logic [1:0]            ob_cnt_q, ob_cnt_d;

    logic       push;
    logic       pop_ob;
    logic       issue;
    logic [2:0] ob_occ;
    logic [1:0] ob_cnt_tmp;

    // A word written this cycle is only counted in sram_cnt from the next cycle, so a read
    // is never issued to the address being written.
    always_comb begin
        in_ready  = rst_n & (sram_cnt_q != SRAM_DEPTH);
        out_valid = (ob_cnt_q != 2'd0);
        push      = in_valid & in_ready;
        pop_ob    = out_valid & out_ready;
        ob_occ    = {1'b0, ob_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop_ob};
        issue     = rst_n & (sram_cnt_q != '0) & (ob_occ < 3'(OB_DEPTH));
    end

    always_comb begin
        wr_ptr_d   = push  ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d   = issue ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        rd_pend_d  = issue;
        sram_cnt_d = sram_cnt_q + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(issue);
    end

    // Prefetch buffer: shift on pop first, then append the captured word behind what remains.
    always_comb begin
        ob_d       = ob_q;
        ob_cnt_tmp = ob_cnt_q;
        if (pop_ob) begin
            for (int i = 0; i < int'(OB_DEPTH) - 1; i++) begin
                ob_d[i] = ob_q[i+1];
            end
            ob_d[OB_DEPTH-1] = '0;
            ob_cnt_tmp       = ob_cnt_q - 2'd1;
        end
        if (rd_pend_q) begin
            for (int i = 0; i < int'(OB_DEPTH); i++) begin
                if (ob_cnt_tmp == 2'(i)) begin
                    ob_d[i] = sram_dout1;
                end
            end
            ob_cnt_tmp = ob_cnt_tmp + 2'd1;
        end
        ob_cnt_d = ob_cnt_tmp;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sram_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            ob_cnt_q   <= '0;
            for (int i = 0; i < int'(OB_DEPTH); i++) begin
                ob_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sram_cnt_q <= sram_cnt_d;
            rd_pend_q  <= rd_pend_d;
            ob_cnt_q   <= ob_cnt_d;
            ob_q       <= ob_d;
        end
    end

    assign out_data   = ob_q[0];
    assign level      = {1'b0, sram_cnt_q} + (ADDR_WIDTH + 2)'(rd_pend_q)
                      + (ADDR_WIDTH + 2)'(ob_cnt_q);
    assign sram_csb0  = ~push;
    assign sram_addr0 = wr_ptr_q;
    assign sram_din0  = in_data;
    assign sram_csb1  = ~issue;
    assign sram_addr1 = rd_ptr_q;

    a_no_rw_collision: assert property (@(posedge clk) disable iff (!rst_n)
        !(!sram_csb0 && !sram_csb1 && (sram_addr0 == sram_addr1)));

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: behavioural SRAM macro plus a queue scoreboard of pushed words.
module tb_sram_fifo_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [11:0] level;
    logic        sram_csb0;
    logic [9:0]  sram_addr0;
    logic [7:0]  sram_din0;
    logic        sram_csb1;
    logic [9:0]  sram_addr1;
    logic [7:0]  sram_dout1;

    int unsigned n_checks;
    int unsigned n_pass;
    logic [7:0]  exp_q[$];
    logic [7:0]  mem [1024];

    sram_fifo_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(10),
        .OB_DEPTH  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .sram_csb0 (sram_csb0),
        .sram_addr0(sram_addr0),
        .sram_din0 (sram_din0),
        .sram_csb1 (sram_csb1),
        .sram_addr1(sram_addr1),
        .sram_dout1(sram_dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: read data valid for one cycle after the issuing edge, junk otherwise.
    always_ff @(posedge clk) begin
        if (!sram_csb0) mem[sram_addr0] <= sram_din0;
        if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
        else            sram_dout1 <= 8'($urandom);
    end

    // Drives one cycle of inputs and reports what handshakes will fire at the next edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r,
                        output logic pushed, output logic popped, output logic [7:0] got,
                        output int lvl_obs, output int lvl_exp, output logic coll);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        lvl_obs = int'(level);
        lvl_exp = exp_q.size();
        pushed  = in_valid & in_ready;
        popped  = out_valid & out_ready;
        got     = out_data;
        coll    = !sram_csb0 && !sram_csb1 && (sram_addr0 == sram_addr1);
        if (pushed) exp_q.push_back(d);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (sram_csb0 !== 1'b1) $display("FAIL reset_csb0: got %b want 1", sram_csb0);
        else n_pass++;
        n_checks++;
        if (sram_csb1 !== 1'b1) $display("FAIL reset_csb1: got %b want 1", sram_csb1);
        else n_pass++;
        n_checks++;
        if (level !== 12'd0) $display("FAIL reset_level: got %0d want 0", level);
        else n_pass++;
        n_checks++;
        if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", out_data);
        else n_pass++;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_latency();
        logic pu, po, cl;
        logic [7:0] g, e;
        int lo, le;
        step(1'b1, 8'hA5, 1'b1, pu, po, g, lo, le, cl);
        n_checks++;
        if (pu !== 1'b1) $display("FAIL lat_push: got %b want 1", pu);
        else n_pass++;
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 8'h00, 1'b1, pu, po, g, lo, le, cl);
            n_checks++;
            if (po !== (k == 3)) $display("FAIL lat_valid_c%0d: got %b want %b", k, po, k == 3);
            else n_pass++;
            n_checks++;
            if (lo !== ((k == 4) ? 0 : 1)) $display("FAIL lat_level_c%0d: got %0d", k, lo);
            else n_pass++;
            if (po) begin
                n_checks++;
                e = exp_q.pop_front();
                if (g !== e) $display("FAIL lat_data: got %h want %h", g, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_fill();
        logic pu, po, cl;
        logic [7:0] g, e;
        int lo, le;
        int n;
        n = 0;
        for (int c = 0; c < 1200; c++) begin
            step(1'b1, 8'(n), 1'b0, pu, po, g, lo, le, cl);
            if (pu) n++;
        end
        n_checks++;
        if (n != 1026) $display("FAIL fill_accepted: got %0d words want 1026", n);
        else n_pass++;
        step(1'b1, 8'hEE, 1'b0, pu, po, g, lo, le, cl);
        n_checks++;
        if (pu !== 1'b0) $display("FAIL fill_full_push: in_ready got %b want 0", in_ready);
        else n_pass++;
        n_checks++;
        if (lo != 1026) $display("FAIL fill_level: got %0d want 1026", lo);
        else n_pass++;
        // Pop while full: slot only frees for the following cycle.
        step(1'b1, 8'(n), 1'b1, pu, po, g, lo, le, cl);
        n_checks++;
        if (pu !== 1'b0 || po !== 1'b1) $display("FAIL fill_pop_full: push %b pop %b want 0 1", pu, po);
        else n_pass++;
        if (po && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL fill_data: got %h want %h", g, e);
            else n_pass++;
        end
        step(1'b1, 8'(n), 1'b1, pu, po, g, lo, le, cl);
        n_checks++;
        if (pu !== 1'b1) $display("FAIL fill_slot_freed: push got %b want 1", pu);
        else n_pass++;
        if (po && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL fill_data: got %h want %h", g, e);
            else n_pass++;
        end
        for (int c = 0; c < 1200 && exp_q.size() > 0; c++) begin
            step(1'b0, 8'h00, 1'b1, pu, po, g, lo, le, cl);
            if (po) begin
                e = exp_q.pop_front();
                n_checks++;
                if (g !== e) $display("FAIL fill_drain_data: got %h want %h", g, e);
                else n_pass++;
            end
        end
        step(1'b0, 8'h00, 1'b0, pu, po, g, lo, le, cl);
        n_checks++;
        if (le != 0 || lo != 0) $display("FAIL fill_drained: level %0d model %0d want 0", lo, le);
        else n_pass++;
    endtask

    task automatic test_streaming();
        logic pu, po, cl;
        logic [7:0] g, e;
        int lo, le;
        for (int k = 0; k < 5000; k++) begin
            step(1'b1, 8'($urandom), 1'b1, pu, po, g, lo, le, cl);
            if (k >= 3) begin
                n_checks++;
                if (!(pu && po)) $display("FAIL stream_bubble_c%0d: push %b pop %b want 1 1", k, pu, po);
                else n_pass++;
            end
            n_checks++;
            if (cl) $display("FAIL stream_collision_c%0d: addr %h both selected", k, sram_addr0);
            else n_pass++;
            if (po) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL stream_dup: popped %h, model empty", g);
                else begin
                    e = exp_q.pop_front();
                    if (g !== e) $display("FAIL stream_data: got %h want %h", g, e);
                    else n_pass++;
                end
            end
        end
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
            step(1'b0, 8'h00, 1'b1, pu, po, g, lo, le, cl);
            if (po) begin
                e = exp_q.pop_front();
                n_checks++;
                if (g !== e) $display("FAIL stream_drain_data: got %h want %h", g, e);
                else n_pass++;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL stream_drain: %0d words left want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic pu, po, cl;
        logic [7:0] g, e;
        int lo, le;
        for (int k = 0; k < 20000; k++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 pu, po, g, lo, le, cl);
            n_checks++;
            if (lo != le) $display("FAIL bp_level_c%0d: got %0d want %0d", k, lo, le);
            else n_pass++;
            n_checks++;
            if (cl) $display("FAIL bp_collision_c%0d: addr %h both selected", k, sram_addr0);
            else n_pass++;
            if (po) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL bp_dup: popped %h, model empty", g);
                else begin
                    e = exp_q.pop_front();
                    if (g !== e) $display("FAIL bp_data: got %h want %h", g, e);
                    else n_pass++;
                end
            end
        end
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            step(1'b0, 8'h00, 1'b1, pu, po, g, lo, le, cl);
            if (po) begin
                e = exp_q.pop_front();
                n_checks++;
                if (g !== e) $display("FAIL bp_drain_data: got %h want %h", g, e);
                else n_pass++;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL bp_drain: %0d words left want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic pu, po, cl;
        logic [7:0] g, e;
        int lo, le;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h3C + i), 1'b0, pu, po, g, lo, le, cl);
        end
        // One pop with a full buffer issues a read, leaving a capture pending.
        step(1'b0, 8'h00, 1'b1, pu, po, g, lo, le, cl);
        n_checks++;
        if (po !== 1'b1 || sram_csb1 !== 1'b0) $display("FAIL mrst_issue: pop %b csb1 %b want 1 0", po, sram_csb1);
        else n_pass++;
        if (po) begin
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL mrst_data: got %h want %h", g, e);
            else n_pass++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        n_checks++;
        if (int'(level) != exp_q.size()) $display("FAIL mrst_level_pre: got %0d want %0d", level, exp_q.size());
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || level !== 12'd0) $display("FAIL mrst_empty: valid %b level %0d want 0 0", out_valid, level);
        else n_pass++;
        n_checks++;
        if (out_data !== 8'h00) $display("FAIL mrst_out_data: got %h want 00", out_data);
        else n_pass++;
        step(1'b1, 8'h81, 1'b1, pu, po, g, lo, le, cl);
        step(1'b1, 8'h82, 1'b1, pu, po, g, lo, le, cl);
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 8'h00, 1'b1, pu, po, g, lo, le, cl);
            if (po) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL mrst_stale: popped %h, model empty", g);
                else begin
                    e = exp_q.pop_front();
                    if (g !== e) $display("FAIL mrst_post_data: got %h want %h", g, e);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0 || level !== 12'd0) $display("FAIL mrst_final: left %0d level %0d want 0 0", exp_q.size(), level);
        else n_pass++;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_latency();
        test_fill();
        test_streaming();
        test_backpressure();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
